panda_pc_unit: RTL

- Next-generation program-counter unit for the Panda fetch stage.
- Generalises the single-issue PC register with:
  - a parametrised boot address;
  - a four-level redirect priority (trap, exception return, jump, branch);
  - 2/4-byte increment for compressed instructions;
  - stall-safe redirect capture;
  - an integrated return-address stack (RAS) for call/return prediction.
- Sits between the decode/execute redirect sources and the instruction memory address port.

---
 rtl/panda_pkg.sv | 15 +
 rtl/panda_adder.sv | 13 +
 rtl/panda_ras.sv | 55 +++++
 rtl/panda_pc_unit.sv | 88 ++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared types and constants for the Panda fetch-stage PC unit.
package panda_pkg;

  typedef enum logic [2:0] {
    PC_SEL_SEQ,
    PC_SEL_BRANCH,
    PC_SEL_JUMP,
    PC_SEL_MRET,
    PC_SEL_TRAP
  } pc_sel_e;

  localparam int unsigned PC_INC_RVC = 2;
  localparam int unsigned PC_INC_RV  = 4;

endpackage

// File: rtl/panda_adder.sv
// Generic add/subtract unit; the PC unit uses it as its incrementer.
module panda_adder #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             subtract_i,
  output logic [Width-1:0] sum_o
);

  assign sum_o = subtract_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/panda_ras.sv
// Return-address stack: circular buffer with a saturating occupancy count.
module panda_ras #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] top_o,
  output logic             valid_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_top;
  logic [CntW-1:0]  r_count;
  logic [PtrW-1:0]  w_topNext;
  logic             w_full;

  assign w_topNext = r_top + PtrW'(1);
  assign w_full    = (r_count == CntW'(Depth));
  assign valid_o   = (r_count != '0);
  assign top_o     = valid_o ? r_mem[r_top] : '0;

  // When full a push still advances the pointer, silently dropping the oldest entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (push_i && !pop_i) begin
      r_top <= w_topNext;
      if (!w_full) begin
        r_count <= r_count + CntW'(1);
      end
    end else if (pop_i && !push_i && valid_o) begin
      r_top   <= r_top - PtrW'(1);
      r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (push_i && pop_i) begin
        r_mem[r_top] <= data_i;
      end else if (push_i) begin
        r_mem[w_topNext] <= data_i;
      end
    end
  end

endmodule

// File: rtl/panda_pc_unit.sv
// Panda fetch PC unit: prioritised redirects, 2/4-byte increment, stall capture, RAS.
// Optional target-misalignment flag is built when PANDA_PC_MISALIGN_EN is defined.
module panda_pc_unit #(
  parameter int              Width    = 32,
  parameter logic [Width-1:0] BootAddr = '0,
  parameter int              RasDepth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             compressed_i,
  input  logic             trap_i,
  input  logic [Width-1:0] trap_target_i,
  input  logic             mret_i,
  input  logic [Width-1:0] epc_i,
  input  logic             jump_i,
  input  logic [Width-1:0] jump_target_i,
  input  logic             branch_i,
  input  logic [Width-1:0] branch_target_i,
  input  logic             ras_push_i,
  input  logic             ras_pop_i,
  output logic [Width-1:0] pc_o,
  output logic [Width-1:0] pc_inc_o,
  output logic [Width-1:0] ras_top_o,
  output logic             ras_valid_o,
  output logic             misaligned_o
);

  import panda_pkg::*;

  logic [Width-1:0] r_pc;
  logic [Width-1:0] w_pc;
  logic [Width-1:0] w_incAmount;
  pc_sel_e          w_sel;

  always_comb begin
    w_sel = PC_SEL_SEQ;
    if (trap_i)        w_sel = PC_SEL_TRAP;
    else if (mret_i)   w_sel = PC_SEL_MRET;
    else if (jump_i)   w_sel = PC_SEL_JUMP;
    else if (branch_i) w_sel = PC_SEL_BRANCH;
  end

  always_comb begin
    w_pc = r_pc;
    case (w_sel)
      PC_SEL_TRAP:   w_pc = trap_target_i;
      PC_SEL_MRET:   w_pc = epc_i;
      PC_SEL_JUMP:   w_pc = jump_target_i;
      PC_SEL_BRANCH: w_pc = branch_target_i;
      default:       w_pc = r_pc;
    endcase
  end

  assign pc_o        = w_pc;
  assign w_incAmount = compressed_i ? Width'(PC_INC_RVC) : Width'(PC_INC_RV);

  panda_adder #(.Width(Width)) u_incr (
    .a_i        (w_pc),
    .b_i        (w_incAmount),
    .subtract_i (1'b0),
    .sum_o      (pc_inc_o)
  );

  // Stalling reloads pc_o so a redirect seen during a stall is held, not lost.
  always_ff @(posedge clk_i) begin
    if (rst_i)        r_pc <= BootAddr;
    else if (stall_i) r_pc <= w_pc;
    else              r_pc <= pc_inc_o;
  end

  panda_ras #(.Width(Width), .Depth(RasDepth)) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ras_push_i && !stall_i),
    .pop_i   (ras_pop_i && !stall_i),
    .data_i  (pc_inc_o),
    .top_o   (ras_top_o),
    .valid_o (ras_valid_o)
  );

`ifdef PANDA_PC_MISALIGN_EN
  assign misaligned_o = (w_sel != PC_SEL_SEQ) && w_pc[0];
`else
  assign misaligned_o = 1'b0;
`endif

endmodule
